frv_counters: RTL and testbench

- Counter and machine-timer unit sitting directly upstream of the CPU core.
- Produces the `ctr_time`, `ctr_cycle` and `ctr_instret` values and the `int_mtime` interrupt line that the core consumes.
- Honours the core's `ctr_inhibit_cy`, `ctr_inhibit_ir` and `instr_ret` outputs.
- Exposes `mtime`/`mtimecmp` to software through a small memory-mapped slave port using the same req/gnt signalling as the core's data memory bus.

---
 rtl/frv_counters.sv | 155 +++++++++++++++
 tb/tb_frv_counters.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/frv_counters.sv
// frv_counters: cycle/instret counters and a memory-mapped machine timer.
//
// Ports:
//   g_clk, g_reset        clock, asynchronous active-high reset
//   instr_ret             core retired one instruction this cycle
//   ctr_inhibit_cy/_ir    hold the cycle / instret counter
//   ctr_time              current mtime
//   ctr_cycle             cycle counter
//   ctr_instret           instructions-retired counter
//   int_mtime             timer interrupt pending (mtime >= mtimecmp)
//   mmio_req/wen/strb/addr/wdata   slave request (req/gnt handshake)
//   mmio_gnt              request accepted (combinational, always ready)
//   mmio_error/rdata      registered response, one cycle after the grant
//
// Register window at MMIO_BASE (16 bytes, word accesses only):
//   0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32]
module frv_counters #(
   parameter logic [31:0] MMIO_BASE      = 32'h0200_0000,
   parameter int unsigned TIMER_DIV      = 1,
   parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        instr_ret,
   input  logic        ctr_inhibit_cy,
   input  logic        ctr_inhibit_ir,
   output logic [63:0] ctr_time,
   output logic [63:0] ctr_cycle,
   output logic [63:0] ctr_instret,
   output logic        int_mtime,
   input  logic        mmio_req,
   input  logic        mmio_wen,
   input  logic [3:0]  mmio_strb,
   input  logic [31:0] mmio_addr,
   input  logic [31:0] mmio_wdata,
   output logic        mmio_gnt,
   output logic        mmio_error,
   output logic [31:0] mmio_rdata
);

   localparam int unsigned      PSC_W   = 16;
   localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(TIMER_DIV - 1);

   localparam logic [1:0] SEL_TIME_LO = 2'd0;
   localparam logic [1:0] SEL_TIME_HI = 2'd1;
   localparam logic [1:0] SEL_CMP_LO  = 2'd2;
   localparam logic [1:0] SEL_CMP_HI  = 2'd3;

   logic [PSC_W-1:0] psc;
   logic [PSC_W-1:0] psc_nxt;
   logic [63:0]      mtimecmp;
   logic [63:0]      mtime_nxt;
   logic [63:0]      mtimecmp_nxt;
   logic             tick;
   logic             addr_hit;
   logic             bus_wr;
   logic             bus_rd;
   logic [1:0]       reg_sel;
   logic [31:0]      rd_val;

   // Byte-wise merge of write data over the current register half.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   assign mmio_gnt = mmio_req;

   // Address decode: inside the window and word aligned.
   always_comb begin
      addr_hit = (mmio_addr[31:4] == MMIO_BASE[31:4]) && (mmio_addr[1:0] == 2'b00);
      bus_wr   = mmio_req &  mmio_wen & addr_hit;
      bus_rd   = mmio_req & ~mmio_wen & addr_hit;
      reg_sel  = mmio_addr[3:2];
   end

   // Read mux sees register values before this cycle's update.
   always_comb begin
      rd_val = 32'd0;
      case (reg_sel)
         SEL_TIME_LO: rd_val = ctr_time[31:0];
         SEL_TIME_HI: rd_val = ctr_time[63:32];
         SEL_CMP_LO:  rd_val = mtimecmp[31:0];
         SEL_CMP_HI:  rd_val = mtimecmp[63:32];
         default:     rd_val = 32'd0;
      endcase
   end

   // Prescaler, mtime and mtimecmp next state. A bus write to an mtime half
   // overrides the tick for that cycle; the prescaler keeps running.
   always_comb begin
      tick         = (psc == PSC_MAX);
      psc_nxt      = tick ? '0 : psc + PSC_W'(1);
      mtime_nxt    = tick ? ctr_time + 64'd1 : ctr_time;
      mtimecmp_nxt = mtimecmp;
      if (bus_wr) begin
         case (reg_sel)
            SEL_TIME_LO: mtime_nxt = {ctr_time[63:32],
                                      merge_bytes(ctr_time[31:0], mmio_wdata, mmio_strb)};
            SEL_TIME_HI: mtime_nxt = {merge_bytes(ctr_time[63:32], mmio_wdata, mmio_strb),
                                      ctr_time[31:0]};
            SEL_CMP_LO:  mtimecmp_nxt = {mtimecmp[63:32],
                                         merge_bytes(mtimecmp[31:0], mmio_wdata, mmio_strb)};
            SEL_CMP_HI:  mtimecmp_nxt = {merge_bytes(mtimecmp[63:32], mmio_wdata, mmio_strb),
                                         mtimecmp[31:0]};
            default: ;
         endcase
      end
   end

   // Timer state and interrupt; interrupt compares the current registers so
   // a mtimecmp write shows on int_mtime one edge after it lands.
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         psc       <= '0;
         ctr_time  <= 64'd0;
         mtimecmp  <= MTIMECMP_RESET;
         int_mtime <= 1'b0;
      end else begin
         psc       <= psc_nxt;
         ctr_time  <= mtime_nxt;
         mtimecmp  <= mtimecmp_nxt;
         int_mtime <= (ctr_time >= mtimecmp);
      end
   end

   // Cycle and instret counters, wrapping silently.
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         ctr_cycle   <= 64'd0;
         ctr_instret <= 64'd0;
      end else begin
         if (!ctr_inhibit_cy)             ctr_cycle   <= ctr_cycle + 64'd1;
         if (instr_ret && !ctr_inhibit_ir) ctr_instret <= ctr_instret + 64'd1;
      end
   end

   // Bus response; cleared in any cycle without a request.
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         mmio_error <= 1'b0;
         mmio_rdata <= 32'd0;
      end else begin
         mmio_error <= mmio_req & ~addr_hit;
         mmio_rdata <= bus_rd ? rd_val : 32'd0;
      end
   end

endmodule

// File: tb/tb_frv_counters.sv
module tb_frv_counters;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        g_clk;
   logic        g_reset;

   logic        a_ir, a_icy, a_iir, a_req, a_wen;
   logic [3:0]  a_strb;
   logic [31:0] a_addr, a_wdata;
   logic [63:0] a_time, a_cycle, a_instret;
   logic        a_int, a_gnt, a_err;
   logic [31:0] a_rdata;

   logic        b_ir, b_icy, b_iir, b_req, b_wen;
   logic [3:0]  b_strb;
   logic [31:0] b_addr, b_wdata;
   logic [63:0] b_time, b_cycle, b_instret;
   logic        b_int, b_gnt, b_err;
   logic [31:0] b_rdata;

   int errors = 0;
   int checks = 0;

   frv_counters #(.MMIO_BASE(BASE), .TIMER_DIV(1)) dut (
      .g_clk(g_clk), .g_reset(g_reset),
      .instr_ret(a_ir), .ctr_inhibit_cy(a_icy), .ctr_inhibit_ir(a_iir),
      .ctr_time(a_time), .ctr_cycle(a_cycle), .ctr_instret(a_instret),
      .int_mtime(a_int),
      .mmio_req(a_req), .mmio_wen(a_wen), .mmio_strb(a_strb),
      .mmio_addr(a_addr), .mmio_wdata(a_wdata),
      .mmio_gnt(a_gnt), .mmio_error(a_err), .mmio_rdata(a_rdata)
   );

   frv_counters #(.MMIO_BASE(BASE), .TIMER_DIV(4)) dut4 (
      .g_clk(g_clk), .g_reset(g_reset),
      .instr_ret(b_ir), .ctr_inhibit_cy(b_icy), .ctr_inhibit_ir(b_iir),
      .ctr_time(b_time), .ctr_cycle(b_cycle), .ctr_instret(b_instret),
      .int_mtime(b_int),
      .mmio_req(b_req), .mmio_wen(b_wen), .mmio_strb(b_strb),
      .mmio_addr(b_addr), .mmio_wdata(b_wdata),
      .mmio_gnt(b_gnt), .mmio_error(b_err), .mmio_rdata(b_rdata)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus request on dut (sel=0) or dut4 (sel=1); returns at edge+1 with
   // the response visible.
   task automatic do_req(input bit sel, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
      if (!sel) begin
         a_req = 1'b1; a_wen = wen; a_addr = addr; a_wdata = wdata; a_strb = strb;
      end else begin
         b_req = 1'b1; b_wen = wen; b_addr = addr; b_wdata = wdata; b_strb = strb;
      end
      #1;
      chk("gnt", 64'(sel ? b_gnt : a_gnt), 64'd1);
      @(posedge g_clk); #1;
      a_req = 1'b0; a_wen = 1'b0; b_req = 1'b0; b_wen = 1'b0;
   endtask

   initial begin
      g_reset = 1'b1;
      a_ir = 0; a_icy = 0; a_iir = 0; a_req = 0; a_wen = 0; a_strb = 0; a_addr = 0; a_wdata = 0;
      b_ir = 0; b_icy = 0; b_iir = 0; b_req = 0; b_wen = 0; b_strb = 0; b_addr = 0; b_wdata = 0;
      repeat (2) @(posedge g_clk);
      #1;
      chk("rst_time", a_time, 64'd0);
      chk("rst_cycle", a_cycle, 64'd0);
      chk("rst_instret", a_instret, 64'd0);
      chk("rst_int", 64'(a_int), 64'd0);
      chk("rst_err", 64'(a_err), 64'd0);
      chk("rst_rdata", 64'(a_rdata), 64'd0);
      chk("idle_gnt", 64'(a_gnt), 64'd0);

      // Free-running counters on dut, prescaled timer and inhibits on dut4.
      g_reset = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         a_ir  = 1'b1;
         b_ir  = (c == 2 || c == 9);
         b_icy = (c >= 5 && c <= 7);
         @(posedge g_clk); #1;
         if (c == 10) begin
            chk("run10_cycle", a_cycle, 64'd10);
            chk("run10_instret", a_instret, 64'd10);
            chk("run10_time", a_time, 64'd10);
            chk("run10_int", 64'(a_int), 64'd0);
         end
      end
      b_ir = 0; b_icy = 0;
      chk("div4_time", b_time, 64'd3);
      chk("div4_cycle", b_cycle, 64'd10);
      chk("div4_instret", b_instret, 64'd2);

      // Instret held by inhibit even with instr_ret high.
      a_iir = 1'b1;
      repeat (3) @(posedge g_clk);
      #1;
      chk("inh_ir_instret", a_instret, 64'd13);
      chk("inh_ir_cycle", a_cycle, 64'd16);
      a_ir = 0; a_iir = 0;

      // Strobed write over the reset value of mtimecmp, then read back.
      do_req(1'b1, 1'b1, BASE + 32'h8, 32'h0000_AB00, 4'b0010);
      chk("strb_wr_rdata", 64'(b_rdata), 64'd0);
      chk("strb_wr_err", 64'(b_err), 64'd0);
      do_req(1'b1, 1'b0, BASE + 32'h8, 32'd0, 4'd0);
      chk("strb_rd_lo", 64'(b_rdata), 64'hFFFF_ABFF);
      do_req(1'b1, 1'b0, BASE + 32'hC, 32'd0, 4'd0);
      chk("strb_rd_hi", 64'(b_rdata), 64'hFFFF_FFFF);

      // Interrupt rise and fall.
      do_req(1'b0, 1'b1, BASE + 32'h4, 32'd0, 4'hF);
      do_req(1'b0, 1'b1, BASE + 32'h0, 32'h10, 4'hF);
      chk("mtime_set", a_time, 64'h10);
      chk("wr_rdata", 64'(a_rdata), 64'd0);
      do_req(1'b0, 1'b1, BASE + 32'h8, 32'h20, 4'hF);
      do_req(1'b0, 1'b1, BASE + 32'hC, 32'd0, 4'hF);
      chk("cmp_set_int", 64'(a_int), 64'd0);
      repeat (14) @(posedge g_clk);
      #1;
      chk("mtime_at_cmp", a_time, 64'h20);
      chk("int_not_yet", 64'(a_int), 64'd0);
      @(posedge g_clk); #1;
      chk("int_rise", 64'(a_int), 64'd1);
      do_req(1'b0, 1'b1, BASE + 32'hC, 32'd1, 4'hF);
      chk("int_still_high", 64'(a_int), 64'd1);
      @(posedge g_clk); #1;
      chk("int_fall", 64'(a_int), 64'd0);

      // mtime wrap.
      do_req(1'b0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
      do_req(1'b0, 1'b1, BASE + 32'h0, 32'hFFFF_FFFE, 4'hF);
      chk("wrap_fe", a_time, 64'hFFFF_FFFF_FFFF_FFFE);
      @(posedge g_clk); #1;
      chk("wrap_ff", a_time, 64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge g_clk); #1;
      chk("wrap_0", a_time, 64'd0);

      // Errors: out of window, misaligned.
      do_req(1'b0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
      chk("err_oow", 64'(a_err), 64'd1);
      chk("err_oow_rdata", 64'(a_rdata), 64'd0);
      do_req(1'b0, 1'b1, BASE + 32'h2, 32'hFFFF_FFFF, 4'hF);
      chk("err_mis", 64'(a_err), 64'd1);
      chk("err_mis_rdata", 64'(a_rdata), 64'd0);
      chk("err_time", a_time, 64'd2);
      do_req(1'b0, 1'b0, BASE + 32'h0, 32'd0, 4'd0);
      chk("rd_time_lo", 64'(a_rdata), 64'd2);
      chk("rd_err", 64'(a_err), 64'd0);
      @(posedge g_clk); #1;
      chk("idle_rdata", 64'(a_rdata), 64'd0);
      chk("idle_err", 64'(a_err), 64'd0);
      do_req(1'b0, 1'b0, BASE + 32'h8, 32'd0, 4'd0);
      chk("rd_cmp_lo", 64'(a_rdata), 64'h20);
      do_req(1'b0, 1'b0, BASE + 32'hC, 32'd0, 4'd0);
      chk("rd_cmp_hi", 64'(a_rdata), 64'd1);
      do_req(1'b0, 1'b0, BASE + 32'h0, 32'd0, 4'd0);
      chk("rd_time_pending", 64'(a_rdata), 64'd6);

      // Asynchronous reset clears the pending response and counters.
      g_reset = 1'b1;
      #1;
      chk("arst_rdata", 64'(a_rdata), 64'd0);
      chk("arst_time", a_time, 64'd0);
      chk("arst_cycle", a_cycle, 64'd0);
      chk("arst_instret", a_instret, 64'd0);
      chk("arst_b_time", b_time, 64'd0);
      chk("arst_b_cycle", b_cycle, 64'd0);
      @(posedge g_clk); #1;
      g_reset = 1'b0;
      do_req(1'b0, 1'b0, BASE + 32'h8, 32'd0, 4'd0);
      chk("arst_cmp_lo", 64'(a_rdata), 64'hFFFF_FFFF);
      do_req(1'b0, 1'b0, BASE + 32'hC, 32'd0, 4'd0);
      chk("arst_cmp_hi", 64'(a_rdata), 64'hFFFF_FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
